sram_slot_arbiter: RTL and testbench

- Time-slot arbiter that multiplexes the single external 8-bit SRAM among three requesters: ULA video fetch, CPU via the mapper, and a ROM-loader/DMA port.
- Sits between the mapper/ULA and the SRAM pins. It is the scheduling replacement for the fixed two-port memory controller, extended with a third low-priority requester and a fairness rule.
- Runs on the 28 MHz system clock.
- Video gets a guaranteed slot every 4 cycles. CPU and loader share the remaining slot.

---
 rtl/sram_slot_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_sram_slot_arbiter.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_slot_arbiter.sv
// Four-phase time-slot arbiter sharing one external SRAM between video, CPU and loader.
// Optional `define SRAM_ARB_VIDSKIP_EN adds vid_req so an unused video slot serves CPU/loader.
module sram_slot_arbiter #(
  parameter int AW         = 19,
  parameter int DW         = 8,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          mrst_n,
`ifdef SRAM_ARB_VIDSKIP_EN
  input  logic          vid_req,
`endif
  input  logic [AW-1:0] vid_a,
  output logic [DW-1:0] vid_dout,
  output logic          vid_valid,
  input  logic [AW-1:0] cpu_a,
  input  logic [DW-1:0] cpu_din,
  input  logic          cpu_oe_n,
  input  logic          cpu_we_n,
  output logic [DW-1:0] cpu_dout,
  output logic          cpu_ack,
  input  logic          ldr_req,
  input  logic [AW-1:0] ldr_a,
  input  logic [DW-1:0] ldr_din,
  input  logic          ldr_we_n,
  output logic [DW-1:0] ldr_dout,
  output logic          ldr_ack,
  output logic [AW-1:0] sram_a,
  inout  wire  [DW-1:0] sram_d,
  output logic          sram_we_n
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_LDR} owner_t;

  logic [1:0]    phase_q, phase_d;
  logic [SW-1:0] starve_q, starve_d;
  owner_t        owner_q, owner_d;
  logic          wr_q, wr_d;
  logic          skip_q, skip_d;
  logic [AW-1:0] sram_a_q, sram_a_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          oe_q, oe_d;
  logic          we_n_q, we_n_d;
  logic [DW-1:0] vid_dout_q, vid_dout_d;
  logic [DW-1:0] cpu_dout_q, cpu_dout_d;
  logic [DW-1:0] ldr_dout_q, ldr_dout_d;
  logic          vid_valid_q, vid_valid_d;
  logic          cpu_ack_q, cpu_ack_d;
  logic          ldr_ack_q, ldr_ack_d;

  logic vid_skip;
`ifdef SRAM_ARB_VIDSKIP_EN
  assign vid_skip = ~vid_req;
`else
  assign vid_skip = 1'b0;
`endif

  logic cpu_rq;
  logic arb_en, strobe_en, done_en, vid_load, vid_latch;

  assign cpu_rq    = ~cpu_oe_n | ~cpu_we_n;
  // A shared slot is arbitrated one edge before its data phase, strobed next, completed last.
  assign arb_en    = (phase_q == 2'd1) || ((phase_q == 2'd3) && vid_skip);
  assign strobe_en = (phase_q == 2'd2) || ((phase_q == 2'd0) && skip_q);
  assign done_en   = (phase_q == 2'd3) || ((phase_q == 2'd1) && skip_q);
  assign vid_load  = (phase_q == 2'd3) && !vid_skip;
  assign vid_latch = (phase_q == 2'd0) && !skip_q;

  always_comb begin
    phase_d     = phase_q + 2'd1;
    starve_d    = starve_q;
    owner_d     = owner_q;
    wr_d        = wr_q;
    skip_d      = (phase_q == 2'd3) ? vid_skip : skip_q;
    sram_a_d    = sram_a_q;
    wdata_d     = wdata_q;
    oe_d        = oe_q;
    we_n_d      = 1'b1;
    vid_dout_d  = vid_dout_q;
    cpu_dout_d  = cpu_dout_q;
    ldr_dout_d  = ldr_dout_q;
    vid_valid_d = 1'b0;
    cpu_ack_d   = 1'b0;
    ldr_ack_d   = 1'b0;

    if (done_en) begin
      oe_d    = 1'b0;
      owner_d = OWN_NONE;
      wr_d    = 1'b0;
      if (owner_q == OWN_CPU) begin
        cpu_ack_d = 1'b1;
        if (!wr_q) cpu_dout_d = sram_d;
      end else if (owner_q == OWN_LDR) begin
        ldr_ack_d = 1'b1;
        if (!wr_q) ldr_dout_d = sram_d;
      end
    end

    if (strobe_en) we_n_d = !((owner_q != OWN_NONE) && wr_q);

    if (vid_load) sram_a_d = vid_a;

    if (vid_latch) begin
      vid_dout_d  = sram_d;
      vid_valid_d = 1'b1;
    end

    // Arbitration comes last so a completing slot can hand straight over to the next one.
    if (arb_en) begin
      if (cpu_rq && ldr_req) begin
        if (starve_q >= SW'(STARVE_MAX)) begin
          owner_d  = OWN_LDR;
          starve_d = '0;
        end else begin
          owner_d  = OWN_CPU;
          starve_d = starve_q + SW'(1);
        end
      end else if (cpu_rq) begin
        owner_d = OWN_CPU;
      end else if (ldr_req) begin
        owner_d  = OWN_LDR;
        starve_d = '0;
      end else begin
        owner_d = OWN_NONE;
      end

      if (owner_d == OWN_CPU) begin
        sram_a_d = cpu_a;
        wdata_d  = cpu_din;
        wr_d     = ~cpu_we_n;
      end else if (owner_d == OWN_LDR) begin
        sram_a_d = ldr_a;
        wdata_d  = ldr_din;
        wr_d     = ~ldr_we_n;
      end else begin
        wr_d = 1'b0;
      end
      oe_d = wr_d;
    end
  end

  always_ff @(posedge clk or negedge mrst_n) begin
    if (!mrst_n) begin
      phase_q     <= 2'd0;
      starve_q    <= '0;
      owner_q     <= OWN_NONE;
      wr_q        <= 1'b0;
      skip_q      <= 1'b0;
      sram_a_q    <= '0;
      wdata_q     <= '0;
      oe_q        <= 1'b0;
      we_n_q      <= 1'b1;
      vid_dout_q  <= '0;
      cpu_dout_q  <= '0;
      ldr_dout_q  <= '0;
      vid_valid_q <= 1'b0;
      cpu_ack_q   <= 1'b0;
      ldr_ack_q   <= 1'b0;
    end else begin
      phase_q     <= phase_d;
      starve_q    <= starve_d;
      owner_q     <= owner_d;
      wr_q        <= wr_d;
      skip_q      <= skip_d;
      sram_a_q    <= sram_a_d;
      wdata_q     <= wdata_d;
      oe_q        <= oe_d;
      we_n_q      <= we_n_d;
      vid_dout_q  <= vid_dout_d;
      cpu_dout_q  <= cpu_dout_d;
      ldr_dout_q  <= ldr_dout_d;
      vid_valid_q <= vid_valid_d;
      cpu_ack_q   <= cpu_ack_d;
      ldr_ack_q   <= ldr_ack_d;
    end
  end

  assign sram_d    = oe_q ? wdata_q : {DW{1'bz}};
  assign sram_a    = sram_a_q;
  assign sram_we_n = we_n_q;
  assign vid_dout  = vid_dout_q;
  assign vid_valid = vid_valid_q;
  assign cpu_dout  = cpu_dout_q;
  assign cpu_ack   = cpu_ack_q;
  assign ldr_dout  = ldr_dout_q;
  assign ldr_ack   = ldr_ack_q;

endmodule

// File: tb/tb_sram_slot_arbiter.sv
// Directed testbench for sram_slot_arbiter with a behavioural asynchronous SRAM model.
module tb_sram_slot_arbiter;

  logic        clk = 1'b0;
  logic        mrst_n;
  logic [18:0] vid_a;
  logic [7:0]  vid_dout;
  logic        vid_valid;
  logic [18:0] cpu_a;
  logic [7:0]  cpu_din;
  logic        cpu_oe_n, cpu_we_n;
  logic [7:0]  cpu_dout;
  logic        cpu_ack;
  logic        ldr_req;
  logic [18:0] ldr_a;
  logic [7:0]  ldr_din;
  logic        ldr_we_n;
  logic [7:0]  ldr_dout;
  logic        ldr_ack;
  logic [18:0] sram_a;
  wire  [7:0]  sram_d;
  logic        sram_we_n;
`ifdef SRAM_ARB_VIDSKIP_EN
  logic        vid_req;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #18 clk = ~clk;

  sram_slot_arbiter dut (
    .clk(clk), .mrst_n(mrst_n),
`ifdef SRAM_ARB_VIDSKIP_EN
    .vid_req(vid_req),
`endif
    .vid_a(vid_a), .vid_dout(vid_dout), .vid_valid(vid_valid),
    .cpu_a(cpu_a), .cpu_din(cpu_din), .cpu_oe_n(cpu_oe_n), .cpu_we_n(cpu_we_n),
    .cpu_dout(cpu_dout), .cpu_ack(cpu_ack),
    .ldr_req(ldr_req), .ldr_a(ldr_a), .ldr_din(ldr_din), .ldr_we_n(ldr_we_n),
    .ldr_dout(ldr_dout), .ldr_ack(ldr_ack),
    .sram_a(sram_a), .sram_d(sram_d), .sram_we_n(sram_we_n)
  );

  // SRAM model: array written while we_n is low, read asynchronously otherwise.
  logic [7:0] mem [0:(1<<19)-1];
  logic       preloaded = 1'b0;
  logic       tb_wr;
  always @(posedge clk) begin
    if (!preloaded) begin
      mem[19'h00000] <= 8'h00;
      mem[19'h0A000] <= 8'h5A;
      mem[19'h00100] <= 8'h77;
      mem[19'h01234] <= 8'h12;
      mem[19'h2C010] <= 8'h00;
      mem[19'h2C000] <= 8'h00;
      mem[19'h7FFFF] <= 8'h00;
      preloaded      <= 1'b1;
    end else if (!sram_we_n) begin
      mem[sram_a] <= sram_d;
    end
  end
  assign sram_d = (sram_we_n && !tb_wr) ? mem[sram_a] : 8'hzz;

  // Reference phase counter, restarted by reset like the design's.
  logic [1:0] tb_phase;
  always @(posedge clk or negedge mrst_n) begin
    if (!mrst_n) tb_phase <= 2'd0;
    else         tb_phase <= tb_phase + 2'd1;
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic align_phase0();
    int n = 0;
    while (tb_phase != 2'd0 && n < 8) begin
      step();
      n++;
    end
    n_checks++;
    if (tb_phase != 2'd0) begin
      n_errors++;
      $display("FAIL align_phase0: phase %0d required 0", tb_phase);
    end
  endtask

  task automatic test_reset();
    mrst_n = 1'b0;
    step();
    step();
    n_checks++;
    if ({sram_we_n, sram_a} !== {1'b1, 19'h0}) begin
      n_errors++;
      $display("FAIL reset_sram: we_n=%b a=%h required we_n=1 a=00000", sram_we_n, sram_a);
    end
    n_checks++;
    if ({vid_dout, cpu_dout, ldr_dout} !== 24'h0) begin
      n_errors++;
      $display("FAIL reset_dout: vid=%h cpu=%h ldr=%h required 00", vid_dout, cpu_dout, ldr_dout);
    end
    n_checks++;
    if ({vid_valid, cpu_ack, ldr_ack} !== 3'b000) begin
      n_errors++;
      $display("FAIL reset_pulses: valid/cpu_ack/ldr_ack=%b required 000", {vid_valid, cpu_ack, ldr_ack});
    end
    mrst_n = 1'b1;
    step();
    n_checks++;
    if (vid_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_phase_start: vid_valid=%b required 1 in first cycle after phase 0", vid_valid);
    end
    $display("reset: done, phase restart observed");
  endtask

  task automatic test_video();
    tb_wr = 1'b0;
    for (int i = 0; i < 16; i++) begin
      step();
      n_checks++;
      if (vid_valid !== (tb_phase == 2'd1)) begin
        n_errors++;
        $display("FAIL video_valid: phase %0d vid_valid=%b required %b", tb_phase, vid_valid, tb_phase == 2'd1);
      end
      n_checks++;
      if (sram_we_n !== 1'b1) begin
        n_errors++;
        $display("FAIL video_we_n: phase %0d we_n=%b required 1", tb_phase, sram_we_n);
      end
      if (tb_phase == 2'd1) begin
        n_checks++;
        if (vid_dout !== 8'h5A) begin
          n_errors++;
          $display("FAIL video_dout: got %h required 5a", vid_dout);
        end
        $display("video: fetch 0a000 -> %h", vid_dout);
      end
    end
  endtask

  task automatic test_cpu_write();
    tb_wr = 1'b1;
    align_phase0();
    cpu_a = 19'h2C000; cpu_din = 8'hA5; cpu_we_n = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      n_checks++;
      if (sram_we_n !== (tb_phase != 2'd3)) begin
        n_errors++;
        $display("FAIL cpu_wr_we_n: phase %0d we_n=%b required %b", tb_phase, sram_we_n, tb_phase != 2'd3);
      end
      n_checks++;
      if (cpu_ack !== (tb_phase == 2'd0)) begin
        n_errors++;
        $display("FAIL cpu_wr_ack: phase %0d ack=%b required %b", tb_phase, cpu_ack, tb_phase == 2'd0);
      end
      if (tb_phase >= 2'd2) begin
        n_checks++;
        if (sram_a !== 19'h2C000 || sram_d !== 8'hA5) begin
          n_errors++;
          $display("FAIL cpu_wr_bus: phase %0d a=%h d=%h required 2c000/a5", tb_phase, sram_a, sram_d);
        end
      end
      if (cpu_ack) $display("cpu write: 2c000 <= a5 acked");
    end
    cpu_we_n = 1'b1;
    for (int i = 0; i < 4; i++) step();
    n_checks++;
    if (mem[19'h2C000] !== 8'hA5) begin
      n_errors++;
      $display("FAIL cpu_wr_mem: mem[2c000]=%h required a5", mem[19'h2C000]);
    end
  endtask

  // Continuous CPU read against a permanently requesting loader: loader wins every 5th slot.
  task automatic run_contention(input int periods, input logic chk_data, input string tag);
    int k = 0;
    int n_ldr = 0;
    logic exp_c, exp_l;
    for (int i = 0; i < periods * 4; i++) begin
      step();
      exp_c = 1'b0;
      exp_l = 1'b0;
      if (tb_phase == 2'd0) begin
        exp_c = (k % 5) != 4;
        exp_l = (k % 5) == 4;
        k++;
      end
      n_checks++;
      if ({cpu_ack, ldr_ack} !== {exp_c, exp_l}) begin
        n_errors++;
        $display("FAIL %s_ack: slot %0d cpu/ldr ack=%b%b required %b%b", tag, k - 1, cpu_ack, ldr_ack, exp_c, exp_l);
      end
      if (ldr_ack) n_ldr++;
      if (chk_data && exp_c) begin
        n_checks++;
        if (cpu_dout !== 8'h12) begin
          n_errors++;
          $display("FAIL %s_cpu_dout: got %h required 12", tag, cpu_dout);
        end
      end
      if (chk_data && exp_l) begin
        n_checks++;
        if (ldr_dout !== 8'h77) begin
          n_errors++;
          $display("FAIL %s_ldr_dout: got %h required 77", tag, ldr_dout);
        end
      end
      if (cpu_ack || ldr_ack) $display("%s: slot %0d cpu_ack=%b ldr_ack=%b", tag, k - 1, cpu_ack, ldr_ack);
    end
    n_checks++;
    if (n_ldr != periods / 5) begin
      n_errors++;
      $display("FAIL %s_ldr_count: got %0d required %0d", tag, n_ldr, periods / 5);
    end
  endtask

  task automatic test_starvation();
    tb_wr = 1'b0;
    align_phase0();
    cpu_a = 19'h01234; cpu_oe_n = 1'b0;
    ldr_a = 19'h00100; ldr_we_n = 1'b1; ldr_req = 1'b1;
    run_contention(10, 1'b1, "starve");
    cpu_oe_n = 1'b1; ldr_req = 1'b0;
    step();
  endtask

  task automatic test_loader_write();
    tb_wr = 1'b1;
    align_phase0();
    ldr_a = 19'h7FFFF; ldr_din = 8'h3C; ldr_we_n = 1'b0; ldr_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++;
      if ({ldr_ack, cpu_ack} !== {tb_phase == 2'd0, 1'b0}) begin
        n_errors++;
        $display("FAIL ldr_wr_ack: phase %0d ldr/cpu ack=%b%b required %b0", tb_phase, ldr_ack, cpu_ack, tb_phase == 2'd0);
      end
      n_checks++;
      if (sram_we_n !== (tb_phase != 2'd3)) begin
        n_errors++;
        $display("FAIL ldr_wr_we_n: phase %0d we_n=%b required %b", tb_phase, sram_we_n, tb_phase != 2'd3);
      end
      if (tb_phase >= 2'd2) begin
        n_checks++;
        if (sram_a !== 19'h7FFFF || sram_d !== 8'h3C) begin
          n_errors++;
          $display("FAIL ldr_wr_bus: phase %0d a=%h d=%h required 7ffff/3c", tb_phase, sram_a, sram_d);
        end
      end
    end
    ldr_req = 1'b0; ldr_we_n = 1'b1;
    $display("loader write: 7ffff <= 3c");
    for (int i = 0; i < 4; i++) step();
    n_checks++;
    if (mem[19'h7FFFF] !== 8'h3C) begin
      n_errors++;
      $display("FAIL ldr_wr_mem: mem[7ffff]=%h required 3c", mem[19'h7FFFF]);
    end
  endtask

  task automatic test_reset_midwrite();
    tb_wr = 1'b1;
    align_phase0();
    // Two contended CPU reads leave the starve counter at 2 before the aborted write.
    cpu_a = 19'h01234; cpu_oe_n = 1'b0;
    ldr_a = 19'h00100; ldr_we_n = 1'b1; ldr_req = 1'b1;
    for (int i = 0; i < 8; i++) step();
    cpu_oe_n = 1'b1; cpu_we_n = 1'b0; cpu_a = 19'h2C010; cpu_din = 8'h99;
    for (int i = 0; i < 3; i++) step();
    n_checks++;
    if (sram_we_n !== 1'b0) begin
      n_errors++;
      $display("FAIL rst_pre_strobe: we_n=%b required 0 before reset", sram_we_n);
    end
    mrst_n = 1'b0;
    #1;
    n_checks++;
    if (sram_we_n !== 1'b1) begin
      n_errors++;
      $display("FAIL rst_async_we_n: we_n=%b required 1 right after reset", sram_we_n);
    end
    step();
    n_checks++;
    if ({cpu_ack, ldr_ack, sram_a} !== {2'b00, 19'h0}) begin
      n_errors++;
      $display("FAIL rst_no_ack: ack=%b%b a=%h required 00/00000", cpu_ack, ldr_ack, sram_a);
    end
    cpu_we_n = 1'b1; cpu_oe_n = 1'b0; cpu_a = 19'h01234;
    mrst_n = 1'b1;
    $display("reset mid-write: write to 2c010 aborted");
    run_contention(5, 1'b0, "post_rst");
    cpu_oe_n = 1'b1; ldr_req = 1'b0;
    for (int i = 0; i < 4; i++) step();
    n_checks++;
    if (mem[19'h2C010] !== 8'h00) begin
      n_errors++;
      $display("FAIL rst_mem_untouched: mem[2c010]=%h required 00", mem[19'h2C010]);
    end
  endtask

`ifdef SRAM_ARB_VIDSKIP_EN
  task automatic test_vidskip();
    tb_wr = 1'b0;
    align_phase0();
    cpu_a = 19'h01234; cpu_oe_n = 1'b0; vid_req = 1'b0;
    for (int i = 0; i < 4; i++) step();
    for (int i = 0; i < 8; i++) begin
      step();
      n_checks++;
      if ({cpu_ack, vid_valid} !== {tb_phase[0] == 1'b0, 1'b0}) begin
        n_errors++;
        $display("FAIL vidskip_ack: phase %0d ack/valid=%b%b required %b0", tb_phase, cpu_ack, vid_valid, tb_phase[0] == 1'b0);
      end
      if (cpu_ack) begin
        n_checks++;
        if (cpu_dout !== 8'h12) begin
          n_errors++;
          $display("FAIL vidskip_dout: got %h required 12", cpu_dout);
        end
        $display("vidskip: phase %0d cpu read 01234 -> %h", tb_phase, cpu_dout);
      end
    end
    cpu_oe_n = 1'b1; vid_req = 1'b1;
    for (int i = 0; i < 4; i++) step();
  endtask
`endif

  initial begin
    vid_a = 19'h0A000;
    cpu_a = '0; cpu_din = '0; cpu_oe_n = 1'b1; cpu_we_n = 1'b1;
    ldr_req = 1'b0; ldr_a = '0; ldr_din = '0; ldr_we_n = 1'b1;
    tb_wr = 1'b0;
`ifdef SRAM_ARB_VIDSKIP_EN
    vid_req = 1'b1;
`endif
    test_reset();
    test_video();
    test_cpu_write();
    test_starvation();
    test_loader_write();
    test_reset_midwrite();
`ifdef SRAM_ARB_VIDSKIP_EN
    test_vidskip();
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
